// File: rtl/timer_a_base_pkg.sv
// Timer A shared parameters: register offsets, TAxCTL bit positions, MC/TASSEL encodings.
// Also used by the CCM blocks of the same Timer A instance.
package timer_a_base_pkg;

    localparam logic [15:0] TA0CTL = 16'h0340;
    localparam logic [15:0] TA0R   = 16'h0350;
    localparam logic [15:0] TA0EX0 = 16'h0360;

    localparam int CTL_TASSEL = 8;
    localparam int CTL_ID     = 6;
    localparam int CTL_MC     = 4;
    localparam int CTL_TACLR  = 2;
    localparam int CTL_TAIE   = 1;
    localparam int CTL_TAIFG  = 0;

    localparam logic [1:0] MC_STOP = 2'b00;
    localparam logic [1:0] MC_UP   = 2'b01;
    localparam logic [1:0] MC_CONT = 2'b10;
    localparam logic [1:0] MC_UPDN = 2'b11;

    localparam logic [1:0] TASSEL_TACLK = 2'b00;
    localparam logic [1:0] TASSEL_ACLK  = 2'b01;
    localparam logic [1:0] TASSEL_SMCLK = 2'b10;
    localparam logic [1:0] TASSEL_INCLK = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef struct packed {
        logic [1:0] tassel;
        logic [1:0] id;
        logic [1:0] mc;
        logic       taie;
        logic       taifg;
    } tactl_t;

    // TACLR (bit 2) and unused bits always read back as 0
    function automatic logic [15:0] ctl_pack(input tactl_t c);
        return {6'd0, c.tassel, c.id, c.mc, 2'b00, c.taie, c.taifg};
    endfunction

endpackage

// File: rtl/timer_a_prescaler.sv
// Source select, 2-flop synchronizer, edge detect and 1..64 divider producing div_tick.
// Source edge reaches src_tick after 3 MCLK; div_tick is combinational from src_tick; no backpressure.
module timer_a_prescaler
    import timer_a_base_pkg::*;
(
    input  logic       MCLK,
    input  logic       reset,
    input  logic [1:0] tassel,
    input  logic [1:0] id,
    input  logic [2:0] idex,
    input  logic       run,
    input  logic       clr,
    input  logic       TACLK,
    input  logic       ACLK,
    input  logic       SMCLK,
    input  logic       INCLK,
    output logic       div_tick
);

    logic       src_sel;
    logic       sync1, sync2, sync3, src_tick;
    logic [5:0] div_cnt, div_term;

    always_comb begin
        src_sel = INCLK;
        case (tassel)
            TASSEL_TACLK: src_sel = TACLK;
            TASSEL_ACLK:  src_sel = ACLK;
            TASSEL_SMCLK: src_sel = SMCLK;
            TASSEL_INCLK: src_sel = INCLK;
        endcase
    end

    // Divide of 64 wraps the 6-bit product to 0, so the minus one still lands on 63
    assign div_term = (({3'd0, idex} + 6'd1) << id) - 6'd1;
    assign div_tick = src_tick & run & ~clr & (div_cnt == div_term);

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
            src_tick <= 1'b0;
            div_cnt  <= '0;
        end else begin
            sync1    <= src_sel;
            sync2    <= sync1;
            sync3    <= sync2;
            src_tick <= sync2 & ~sync3;
            if (clr)
                div_cnt <= '0;
            else if (src_tick && run)
                div_cnt <= (div_cnt == div_term) ? 6'd0 : div_cnt + 6'd1;
        end
    end

endmodule

// File: rtl/timer_a_base.sv
// Timer A base: TAxR counter, stop/up/continuous/up-down control and TAxCTL/TAxR/TAxEX0 registers.
// TAxR steps on the edge ending the TimerClock cycle; bus accesses never stall.
module timer_a_base
    import timer_a_base_pkg::*;
#(
    parameter logic [15:0] CTL_OFFSET = TA0CTL,
    parameter logic [15:0] R_OFFSET   = TA0R,
    parameter logic [15:0] EX_OFFSET  = TA0EX0
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic [15:0] MAB,
    input  logic [15:0] MDBwrite,
    input  logic        MW,
    input  logic        BW,
    input  logic        TACLK,
    input  logic        ACLK,
    input  logic        SMCLK,
    input  logic        INCLK,
    input  logic        EQU0,
    input  logic        TAIFGclr,
    output logic [15:0] TAxRcurrent,
    output logic        TimerClock,
    output logic        TAIFG,
    output logic        TAIE,
    output logic [15:0] MDBread
);

    tactl_t      ctl;
    logic [2:0]  taidex;
    logic [15:0] tar, tar_step, rd_val, rd_dat;
    logic        dir, dir_nxt;
    logic [15:0] addr_w;
    logic [7:0]  dat_lo, dat_hi;
    logic        sel_ctl, sel_r, sel_ex, wr_lo, wr_hi;
    logic        wr_ctl, wr_r, wr_ex, taclr_wr, presc_clr, div_tick;
    logic        step, ifg_step, ifg_set;

    assign addr_w  = {MAB[15:1], 1'b0};
    assign sel_ctl = (addr_w == CTL_OFFSET);
    assign sel_r   = (addr_w == R_OFFSET);
    assign sel_ex  = (addr_w == EX_OFFSET);
    assign wr_lo   = ~BW | ~MAB[0];
    assign wr_hi   = ~BW |  MAB[0];
    assign dat_lo  = MDBwrite[7:0];
    assign dat_hi  = BW ? MDBwrite[7:0] : MDBwrite[15:8];
    assign wr_ctl  = MW & sel_ctl;
    assign wr_r    = MW & sel_r;
    assign wr_ex   = MW & sel_ex;

    assign taclr_wr  = wr_ctl & wr_lo & dat_lo[CTL_TACLR];
    assign presc_clr = taclr_wr | (wr_ctl & wr_lo) | (wr_ex & wr_lo);

    timer_a_prescaler u_presc (
        .MCLK     (MCLK),
        .reset    (reset),
        .tassel   (ctl.tassel),
        .id       (ctl.id),
        .idex     (taidex),
        .run      (ctl.mc != MC_STOP),
        .clr      (presc_clr),
        .TACLK    (TACLK),
        .ACLK     (ACLK),
        .SMCLK    (SMCLK),
        .INCLK    (INCLK),
        .div_tick (div_tick)
    );

    // EQU0 with TAxR==0 means CCR0 is 0: the count parks at zero
    always_comb begin
        tar_step = tar + 16'd1;
        ifg_step = 1'b0;
        dir_nxt  = dir;
        case (ctl.mc)
            MC_CONT: ifg_step = (tar == 16'hFFFF);
            MC_UP: begin
                if (EQU0) begin
                    tar_step = '0;
                    ifg_step = (tar != 16'd0);
                end
            end
            MC_UPDN: begin
                if (dir == DIR_DOWN) begin
                    if (tar <= 16'd1) begin
                        tar_step = '0;
                        ifg_step = (tar == 16'd1);
                        dir_nxt  = DIR_UP;
                    end else begin
                        tar_step = tar - 16'd1;
                    end
                end else if (EQU0) begin
                    if (tar != 16'd0) begin
                        tar_step = tar - 16'd1;
                        dir_nxt  = DIR_DOWN;
                    end else begin
                        tar_step = '0;
                    end
                end
            end
            default: tar_step = tar;
        endcase
    end

    assign step    = TimerClock & (ctl.mc != MC_STOP);
    assign ifg_set = step & ifg_step & ~taclr_wr & ~wr_r;

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            ctl        <= '0;
            taidex     <= '0;
            tar        <= '0;
            dir        <= DIR_UP;
            TimerClock <= 1'b0;
        end else begin
            TimerClock <= div_tick & (ctl.mc != MC_STOP);
            if (wr_ctl && wr_hi)
                ctl.tassel <= dat_hi[CTL_TASSEL-8 +: 2];
            if (wr_ctl && wr_lo) begin
                ctl.id   <= dat_lo[CTL_ID +: 2];
                ctl.mc   <= dat_lo[CTL_MC +: 2];
                ctl.taie <= dat_lo[CTL_TAIE];
            end
            if (ifg_set)
                ctl.taifg <= 1'b1;
            else if (wr_ctl && wr_lo)
                ctl.taifg <= dat_lo[CTL_TAIFG];
            else if (TAIFGclr)
                ctl.taifg <= 1'b0;
            if (wr_ex && wr_lo)
                taidex <= dat_lo[2:0];
            if (taclr_wr) begin
                tar <= '0;
            end else if (wr_r) begin
                if (wr_hi) tar[15:8] <= dat_hi;
                if (wr_lo) tar[7:0]  <= dat_lo;
            end else if (step) begin
                tar <= tar_step;
            end
            if (taclr_wr)
                dir <= DIR_UP;
            else if (step && !wr_r)
                dir <= dir_nxt;
        end
    end

    always_comb begin
        rd_val = '0;
        if (sel_ctl)     rd_val = ctl_pack(ctl);
        else if (sel_r)  rd_val = tar;
        else if (sel_ex) rd_val = {13'd0, taidex};
    end

    assign rd_dat      = !BW ? rd_val : (MAB[0] ? {8'h00, rd_val[15:8]} : {8'h00, rd_val[7:0]});
    assign MDBread     = (sel_ctl | sel_r | sel_ex) ? rd_dat : 16'hzzzz;
    assign TAxRcurrent = tar;
    assign TAIFG       = ctl.taifg;
    assign TAIE        = ctl.taie;

endmodule
